adder_seq: RTL

- Parametrised, multi-cycle digit-serial adder/subtractor: successor to the 4-bit combinational adder.
- Operands of WIDTH bits are latched on a start handshake, then processed DIGIT bits per clock with a registered carry chain.
- Returns a WIDTH+1-bit result, signed overflow flag and one-cycle done pulse.
- Used where wide adds must trade latency for area; shares the start/busy/done handshake of the lab datapath blocks.

---
 rtl/adder_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/adder_seq.sv
// Digit-serial adder/subtractor: latches WIDTH-bit operands on start, then
// adds DIGIT bits per clock through a registered carry, LSB digit first.
// Result, carry-out and signed overflow are published with a one-cycle done pulse.
module adder_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    if ((WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_param_err
        $fatal(1, "adder_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   dig_sum;
    logic             msb_cin;
    logic [WIDTH-1:0] res_shift;
    logic             accept;
    logic             last_digit;

    // One digit of the carry chain; the carry into the digit's top bit is
    // recovered from its sum bit, so ovf needs no separate adder.
    assign a_dig     = a_q[DIGIT-1:0];
    assign b_dig     = b_q[DIGIT-1:0];
    assign dig_sum   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    assign msb_cin   = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    // New digit enters at the top so the LSB digit ends up at bit 0.
    assign res_shift = (res_q >> DIGIT)
                     | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign accept     = (state_q == StIdle) && start;
    assign last_digit = (state_q == StRun) && (cnt_q == LastCnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == LastCnt) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next-state values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        if (accept) begin
            // Subtraction is a + ~b + 1; sub is captured by the inversion and carry.
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            res_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (state_q == StRun) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_shift;
            carry_d = dig_sum[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (last_digit) begin
                sum_d  = {dig_sum[DIGIT], res_shift};
                ovf_d  = msb_cin ^ dig_sum[DIGIT];
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign ovf  = ovf_q;

endmodule
